// File: rtl/sargantana_icache_refill_ctrl.sv
//==============================================================================
// Module   : sargantana_icache_refill_ctrl
// Purpose  : Instruction-cache refill and flush controller. It accepts a miss
//            (tag, set index, victim way), fetches the line from L2 and writes
//            tag, valid bit and line into the victim way. It also sequences
//            cache flushes.
// Config   : ICACHE_FLUSH_WALK_EN defined   -> flush walks every set, clearing
//                                              the valid bits one set per cycle
//            ICACHE_FLUSH_WALK_EN undefined -> single-cycle bulk flush using
//                                              flush_en_o
// Ports    : clk_i, rst_i                    clock / sync active-high reset
//            miss_*                          miss request from lookup FSM
//            flush_i, busy_o, *_done_o       flush request and status pulses
//            l2_req_* / l2_rsp_*             L2 request / response channel
//            tag_req_o .. addr_o             tag/data array write port
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module sargantana_icache_refill_ctrl #(
    parameter int ICACHE_N_WAY = 4,
    parameter int TAG_WIDHT    = 20,
    parameter int SET_WIDHT    = 256,
    parameter int ADDR_WIDHT   = 6
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    miss_valid_i,
    output logic                    miss_ready_o,
    input  logic [TAG_WIDHT-1:0]    miss_tag_i,
    input  logic [ADDR_WIDHT-1:0]   miss_idx_i,
    input  logic [ICACHE_N_WAY-1:0] miss_way_i,
    input  logic                    flush_i,
    output logic                    busy_o,
    output logic                    refill_done_o,
    output logic                    flush_done_o,
    output logic                    l2_req_valid_o,
    input  logic                    l2_req_ready_i,
    output logic [TAG_WIDHT-1:0]    l2_req_tag_o,
    output logic [ADDR_WIDHT-1:0]   l2_req_idx_o,
    input  logic                    l2_rsp_valid_i,
    input  logic [SET_WIDHT-1:0]    l2_rsp_data_i,
    input  logic                    l2_rsp_error_i,
    output logic [ICACHE_N_WAY-1:0] tag_req_o,
    output logic [ICACHE_N_WAY-1:0] data_req_o,
    output logic                    tag_we_o,
    output logic                    data_we_o,
    output logic                    flush_en_o,
    output logic                    valid_bit_o,
    output logic [TAG_WIDHT-1:0]    tag_o,
    output logic [SET_WIDHT-1:0]    cline_o,
    output logic [ADDR_WIDHT-1:0]   addr_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_FLUSH = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_flush_pending;
    logic [TAG_WIDHT-1:0]    r_tag;
    logic [ADDR_WIDHT-1:0]   r_idx;
    logic [ICACHE_N_WAY-1:0] r_way;
    logic [SET_WIDHT-1:0]    r_data;
    logic                    r_error;
    logic                    w_miss_fire;
    logic                    w_rsp_fire;

`ifdef ICACHE_FLUSH_WALK_EN
    logic [ADDR_WIDHT-1:0]   r_flush_cnt;
    logic                    w_flush_last;

    assign w_flush_last = (r_flush_cnt == {ADDR_WIDHT{1'b1}});
`endif

    assign w_miss_fire = miss_valid_i && miss_ready_o;
    assign w_rsp_fire  = (r_state == ST_WAIT) && l2_rsp_valid_i;

    //--------------------------------------------------------------------------
    // State and datapath registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state         <= ST_IDLE;
            r_flush_pending <= 1'b0;
            r_tag           <= '0;
            r_idx           <= '0;
            r_way           <= '0;
            r_data          <= '0;
            r_error         <= 1'b0;
        end else begin
            r_state <= w_next_state;

            // Entry into FLUSH consumes the pending request; a flush seen
            // while busy is remembered until the current operation finishes.
            if (w_next_state == ST_FLUSH && r_state != ST_FLUSH) begin
                r_flush_pending <= 1'b0;
            end else if (flush_i && r_state != ST_IDLE) begin
                r_flush_pending <= 1'b1;
            end

            if (w_miss_fire) begin
                r_tag <= miss_tag_i;
                r_idx <= miss_idx_i;
                r_way <= miss_way_i;
            end

            if (w_rsp_fire) begin
                r_data  <= l2_rsp_data_i;
                r_error <= l2_rsp_error_i;
            end
        end
    end

`ifdef ICACHE_FLUSH_WALK_EN
    // Walk counter returns to zero as the flush ends, so every flush
    // starts from set 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_flush_cnt <= '0;
        end else if (r_state == ST_FLUSH) begin
            r_flush_cnt <= w_flush_last ? '0 : r_flush_cnt + ADDR_WIDHT'(1);
        end
    end
`endif

    //--------------------------------------------------------------------------
    // Next state and outputs. Everything is forced low while rst_i is high so
    // an aborted WRITE never strobes the arrays in the reset cycle.
    //--------------------------------------------------------------------------
    always_comb begin
        w_next_state   = r_state;
        miss_ready_o   = 1'b0;
        busy_o         = 1'b0;
        refill_done_o  = 1'b0;
        flush_done_o   = 1'b0;
        l2_req_valid_o = 1'b0;
        l2_req_tag_o   = '0;
        l2_req_idx_o   = '0;
        tag_req_o      = '0;
        data_req_o     = '0;
        tag_we_o       = 1'b0;
        data_we_o      = 1'b0;
        flush_en_o     = 1'b0;
        valid_bit_o    = 1'b0;
        tag_o          = '0;
        cline_o        = '0;
        addr_o         = '0;

        if (!rst_i) begin
            busy_o = (r_state != ST_IDLE) || r_flush_pending;
            case (r_state)
                ST_IDLE: begin
                    miss_ready_o = !flush_i && !r_flush_pending;
                    if (flush_i || r_flush_pending) begin
                        w_next_state = ST_FLUSH;
                    end else if (miss_valid_i) begin
                        w_next_state = ST_REQ;
                    end
                end
                ST_REQ: begin
                    l2_req_valid_o = 1'b1;
                    l2_req_tag_o   = r_tag;
                    l2_req_idx_o   = r_idx;
                    if (l2_req_ready_i) begin
                        w_next_state = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (l2_rsp_valid_i) begin
                        w_next_state = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    tag_req_o     = r_way;
                    data_req_o    = r_way;
                    tag_we_o      = 1'b1;
                    data_we_o     = 1'b1;
                    addr_o        = r_idx;
                    tag_o         = r_tag;
                    cline_o       = r_data;
                    valid_bit_o   = !r_error;
                    refill_done_o = 1'b1;
                    w_next_state  = ST_IDLE;
                end
                ST_FLUSH: begin
                    tag_req_o = '1;
`ifdef ICACHE_FLUSH_WALK_EN
                    tag_we_o  = 1'b1;
                    addr_o    = r_flush_cnt;
                    if (w_flush_last) begin
                        flush_done_o = 1'b1;
                        w_next_state = ST_IDLE;
                    end
`else
                    flush_en_o   = 1'b1;
                    flush_done_o = 1'b1;
                    w_next_state = ST_IDLE;
`endif
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sargantana_icache_refill_ctrl.sv
//==============================================================================
// Module   : tb_sargantana_icache_refill_ctrl
// Purpose  : Directed self-checking bench for the icache refill/flush
//            controller. Inputs change 1 ns after the rising edge and
//            outputs are sampled 1 ns later, well away from the next edge.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sargantana_icache_refill_ctrl;

    localparam int ICACHE_N_WAY = 4;
    localparam int TAG_WIDHT    = 20;
    localparam int SET_WIDHT    = 256;
    localparam int ADDR_WIDHT   = 6;
`ifdef ICACHE_FLUSH_WALK_EN
    localparam int FLUSH_CYCLES = 64;
`else
    localparam int FLUSH_CYCLES = 1;
`endif

    localparam logic [SET_WIDHT-1:0] LINE_A =
        256'h0011223344556677_8899AABBCCDDEEFF_0F1E2D3C4B5A6978_F0E1D2C3B4A59687;
    localparam logic [SET_WIDHT-1:0] LINE_B =
        256'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0_A5A5A5A5_5A5A5A5A_FFFF0000_0000FFFF;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic                    miss_valid_i;
    logic                    miss_ready_o;
    logic [TAG_WIDHT-1:0]    miss_tag_i;
    logic [ADDR_WIDHT-1:0]   miss_idx_i;
    logic [ICACHE_N_WAY-1:0] miss_way_i;
    logic                    flush_i;
    logic                    busy_o;
    logic                    refill_done_o;
    logic                    flush_done_o;
    logic                    l2_req_valid_o;
    logic                    l2_req_ready_i;
    logic [TAG_WIDHT-1:0]    l2_req_tag_o;
    logic [ADDR_WIDHT-1:0]   l2_req_idx_o;
    logic                    l2_rsp_valid_i;
    logic [SET_WIDHT-1:0]    l2_rsp_data_i;
    logic                    l2_rsp_error_i;
    logic [ICACHE_N_WAY-1:0] tag_req_o;
    logic [ICACHE_N_WAY-1:0] data_req_o;
    logic                    tag_we_o;
    logic                    data_we_o;
    logic                    flush_en_o;
    logic                    valid_bit_o;
    logic [TAG_WIDHT-1:0]    tag_o;
    logic [SET_WIDHT-1:0]    cline_o;
    logic [ADDR_WIDHT-1:0]   addr_o;

    int checks = 0;
    int errors = 0;

    sargantana_icache_refill_ctrl #(
        .ICACHE_N_WAY (ICACHE_N_WAY),
        .TAG_WIDHT    (TAG_WIDHT),
        .SET_WIDHT    (SET_WIDHT),
        .ADDR_WIDHT   (ADDR_WIDHT)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .miss_valid_i   (miss_valid_i),
        .miss_ready_o   (miss_ready_o),
        .miss_tag_i     (miss_tag_i),
        .miss_idx_i     (miss_idx_i),
        .miss_way_i     (miss_way_i),
        .flush_i        (flush_i),
        .busy_o         (busy_o),
        .refill_done_o  (refill_done_o),
        .flush_done_o   (flush_done_o),
        .l2_req_valid_o (l2_req_valid_o),
        .l2_req_ready_i (l2_req_ready_i),
        .l2_req_tag_o   (l2_req_tag_o),
        .l2_req_idx_o   (l2_req_idx_o),
        .l2_rsp_valid_i (l2_rsp_valid_i),
        .l2_rsp_data_i  (l2_rsp_data_i),
        .l2_rsp_error_i (l2_rsp_error_i),
        .tag_req_o      (tag_req_o),
        .data_req_o     (data_req_o),
        .tag_we_o       (tag_we_o),
        .data_we_o      (data_we_o),
        .flush_en_o     (flush_en_o),
        .valid_bit_o    (valid_bit_o),
        .tag_o          (tag_o),
        .cline_o        (cline_o),
        .addr_o         (addr_o)
    );

    always #5 clk_i = ~clk_i;

    // A victim way must be one-hot whenever a miss is handed over.
    always @(negedge clk_i) begin
        if (!rst_i && miss_valid_i && miss_ready_o) begin
            assert ($onehot(miss_way_i))
                else $error("illegal victim way %b", miss_way_i);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Sample point for outputs after inputs have settled.
    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        miss_valid_i   = 1'b0;
        miss_tag_i     = '0;
        miss_idx_i     = '0;
        miss_way_i     = '0;
        flush_i        = 1'b0;
        l2_req_ready_i = 1'b0;
        l2_rsp_valid_i = 1'b0;
        l2_rsp_data_i  = '0;
        l2_rsp_error_i = 1'b0;
    endtask

    // Present a miss in the current (IDLE) cycle and clock it in.
    task automatic accept_miss(input logic [TAG_WIDHT-1:0] tag,
                               input logic [ADDR_WIDHT-1:0] idx,
                               input logic [ICACHE_N_WAY-1:0] way);
        miss_valid_i = 1'b1;
        miss_tag_i   = tag;
        miss_idx_i   = idx;
        miss_way_i   = way;
        settle();
        checks++;
        if (miss_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: got %b expected 1", miss_ready_o);
        end
        tick();
        miss_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        miss_valid_i = 1'b1;
        miss_way_i   = 4'b0001;
        settle();
        checks++;
        if (miss_ready_o !== 1'b0) begin errors++; $display("FAIL rst_miss_ready: got %b expected 0", miss_ready_o); end
        checks++;
        if ({busy_o, l2_req_valid_o, tag_we_o, data_we_o, flush_en_o, refill_done_o, flush_done_o} !== 7'b0) begin
            errors++;
            $display("FAIL rst_ctrl_outputs: got %b expected 0000000",
                     {busy_o, l2_req_valid_o, tag_we_o, data_we_o, flush_en_o, refill_done_o, flush_done_o});
        end
        tick();
        miss_valid_i = 1'b0;
        miss_way_i   = '0;
        rst_i        = 1'b0;
        settle();
        checks++;
        if (miss_ready_o !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", miss_ready_o); end
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_release_busy: got %b expected 0", busy_o); end
    endtask

    task automatic test_basic_refill();
        accept_miss(20'h12345, 6'd5, 4'b0100);
        // N+1: request with zero-wait ready
        l2_req_ready_i = 1'b1;
        settle();
        checks++;
        if ({l2_req_valid_o, l2_req_tag_o, l2_req_idx_o} !== {1'b1, 20'h12345, 6'd5}) begin
            errors++;
            $display("FAIL basic_req: got v=%b tag=%h idx=%0d expected v=1 tag=12345 idx=5",
                     l2_req_valid_o, l2_req_tag_o, l2_req_idx_o);
        end
        checks++;
        if ({miss_ready_o, busy_o} !== 2'b01) begin errors++; $display("FAIL basic_busy: got ready/busy=%b expected 01", {miss_ready_o, busy_o}); end
        tick();
        // N+2: WAIT, response arrives immediately
        l2_req_ready_i = 1'b0;
        l2_rsp_valid_i = 1'b1;
        l2_rsp_data_i  = LINE_A;
        settle();
        checks++;
        if ({l2_req_valid_o, tag_we_o, data_we_o, refill_done_o} !== 4'b0) begin
            errors++;
            $display("FAIL basic_wait: got %b expected 0000", {l2_req_valid_o, tag_we_o, data_we_o, refill_done_o});
        end
        tick();
        // N+3: WRITE
        l2_rsp_valid_i = 1'b0;
        l2_rsp_data_i  = '0;
        settle();
        checks++;
        if ({tag_we_o, data_we_o, refill_done_o, valid_bit_o, flush_en_o} !== 5'b11110) begin
            errors++;
            $display("FAIL basic_write_ctrl: got %b expected 11110", {tag_we_o, data_we_o, refill_done_o, valid_bit_o, flush_en_o});
        end
        checks++;
        if ({tag_req_o, data_req_o, addr_o, tag_o} !== {4'b0100, 4'b0100, 6'd5, 20'h12345}) begin
            errors++;
            $display("FAIL basic_write_addr: got treq=%b dreq=%b addr=%0d tag=%h expected 0100 0100 5 12345",
                     tag_req_o, data_req_o, addr_o, tag_o);
        end
        checks++;
        if (cline_o !== LINE_A) begin errors++; $display("FAIL basic_write_line: got %h expected %h", cline_o, LINE_A); end
        tick();
        settle();
        checks++;
        if ({refill_done_o, tag_we_o, miss_ready_o, busy_o} !== 4'b0010) begin
            errors++;
            $display("FAIL basic_after: got done/we/ready/busy=%b expected 0010", {refill_done_o, tag_we_o, miss_ready_o, busy_o});
        end
    endtask

    task automatic test_req_stall_error();
        int hs = 0;
        accept_miss(20'hABCDE, 6'd33, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            l2_req_ready_i = (i == 4);
            settle();
            checks++;
            if ({l2_req_valid_o, l2_req_tag_o, l2_req_idx_o} !== {1'b1, 20'hABCDE, 6'd33}) begin
                errors++;
                $display("FAIL stall_req[%0d]: got v=%b tag=%h idx=%0d expected v=1 tag=abcde idx=33",
                         i, l2_req_valid_o, l2_req_tag_o, l2_req_idx_o);
            end
            if (l2_req_valid_o && l2_req_ready_i) hs++;
            tick();
        end
        // Ready stays high in WAIT: no second handshake may appear.
        l2_req_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            if (l2_req_valid_o && l2_req_ready_i) hs++;
            tick();
        end
        checks++;
        if (hs !== 1) begin errors++; $display("FAIL stall_handshakes: got %0d expected 1", hs); end
        l2_req_ready_i = 1'b0;
        l2_rsp_valid_i = 1'b1;
        l2_rsp_error_i = 1'b1;
        l2_rsp_data_i  = LINE_B;
        tick();
        l2_rsp_valid_i = 1'b0;
        l2_rsp_error_i = 1'b0;
        settle();
        checks++;
        if ({tag_we_o, data_we_o, refill_done_o, valid_bit_o} !== 4'b1110) begin
            errors++;
            $display("FAIL error_write: got we/dwe/done/valid=%b expected 1110", {tag_we_o, data_we_o, refill_done_o, valid_bit_o});
        end
        checks++;
        if ({tag_req_o, addr_o, cline_o} !== {4'b0001, 6'd33, LINE_B}) begin
            errors++;
            $display("FAIL error_write_addr: got treq=%b addr=%0d expected 0001 33", tag_req_o, addr_o);
        end
        tick();
    endtask

    // Checks the flush sequence starting at the current sample point.
    task automatic check_flush(input string name);
        for (int i = 0; i < FLUSH_CYCLES; i++) begin
            settle();
            checks++;
`ifdef ICACHE_FLUSH_WALK_EN
            if ({tag_req_o, tag_we_o, valid_bit_o, flush_en_o, data_we_o, tag_o, addr_o, flush_done_o} !==
                {4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 20'h0, 6'(i), (i == 63)}) begin
                errors++;
                $display("FAIL %s_walk[%0d]: got treq=%b we=%b vb=%b fen=%b addr=%0d done=%b expected 1111 1 0 0 %0d %b",
                         name, i, tag_req_o, tag_we_o, valid_bit_o, flush_en_o, addr_o, flush_done_o, i, (i == 63));
            end
`else
            if ({tag_req_o, tag_we_o, flush_en_o, data_we_o, flush_done_o} !== {4'b1111, 1'b0, 1'b1, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL %s_flush: got treq=%b we=%b fen=%b dwe=%b done=%b expected 1111 0 1 0 1",
                         name, tag_req_o, tag_we_o, flush_en_o, data_we_o, flush_done_o);
            end
`endif
            tick();
        end
    endtask

    task automatic test_flush_during_wait();
        accept_miss(20'h00F0F, 6'd63, 4'b1000);
        l2_req_ready_i = 1'b1;
        tick();
        l2_req_ready_i = 1'b0;
        flush_i        = 1'b1;
        tick();
        flush_i = 1'b0;
        settle();
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL fwait_busy: got %b expected 1", busy_o); end
        l2_rsp_valid_i = 1'b1;
        l2_rsp_data_i  = LINE_A;
        tick();
        l2_rsp_valid_i = 1'b0;
        settle();
        checks++;
        if ({refill_done_o, tag_we_o, data_we_o, flush_en_o} !== 4'b1110) begin
            errors++;
            $display("FAIL fwait_write: got %b expected 1110", {refill_done_o, tag_we_o, data_we_o, flush_en_o});
        end
        tick();
        // IDLE with the flush still pending: miss refused, heading to FLUSH.
        settle();
        checks++;
        if ({miss_ready_o, busy_o, tag_we_o} !== 3'b010) begin
            errors++;
            $display("FAIL fwait_pending: got ready/busy/we=%b expected 010", {miss_ready_o, busy_o, tag_we_o});
        end
        tick();
        check_flush("fwait");
        settle();
        checks++;
        if ({miss_ready_o, busy_o, flush_done_o, tag_we_o, flush_en_o} !== 5'b10000) begin
            errors++;
            $display("FAIL fwait_end: got %b expected 10000", {miss_ready_o, busy_o, flush_done_o, tag_we_o, flush_en_o});
        end
    endtask

    task automatic test_flush_vs_miss();
        flush_i      = 1'b1;
        miss_valid_i = 1'b1;
        miss_tag_i   = 20'h5A5A5;
        miss_idx_i   = 6'd17;
        miss_way_i   = 4'b0010;
        settle();
        checks++;
        if (miss_ready_o !== 1'b0) begin errors++; $display("FAIL fvm_ready: got %b expected 0", miss_ready_o); end
        tick();
        flush_i = 1'b0;
        check_flush("fvm");
        // Miss has been held valid throughout; it is taken now.
        settle();
        checks++;
        if (miss_ready_o !== 1'b1) begin errors++; $display("FAIL fvm_ready_after: got %b expected 1", miss_ready_o); end
        tick();
        miss_valid_i   = 1'b0;
        l2_req_ready_i = 1'b1;
        settle();
        checks++;
        if ({l2_req_valid_o, l2_req_tag_o, l2_req_idx_o} !== {1'b1, 20'h5A5A5, 6'd17}) begin
            errors++;
            $display("FAIL fvm_req: got v=%b tag=%h idx=%0d expected v=1 tag=5a5a5 idx=17",
                     l2_req_valid_o, l2_req_tag_o, l2_req_idx_o);
        end
        tick();
        l2_req_ready_i = 1'b0;
        l2_rsp_valid_i = 1'b1;
        tick();
        l2_rsp_valid_i = 1'b0;
        settle();
        checks++;
        if ({tag_req_o, refill_done_o} !== {4'b0010, 1'b1}) begin
            errors++;
            $display("FAIL fvm_write: got treq=%b done=%b expected 0010 1", tag_req_o, refill_done_o);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        accept_miss(20'h0BEEF, 6'd9, 4'b0100);
        l2_req_ready_i = 1'b1;
        tick();
        l2_req_ready_i = 1'b0;
        flush_i        = 1'b1;
        tick();
        // In WAIT with a pending flush: reset and a response together.
        flush_i        = 1'b0;
        rst_i          = 1'b1;
        l2_rsp_valid_i = 1'b1;
        l2_rsp_data_i  = LINE_B;
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++;
            if ({tag_we_o, data_we_o, refill_done_o, miss_ready_o, busy_o, tag_req_o} !== 9'b0) begin
                errors++;
                $display("FAIL rmid_in_reset[%0d]: got we/dwe/done/ready/busy/treq=%b expected 0",
                         i, {tag_we_o, data_we_o, refill_done_o, miss_ready_o, busy_o, tag_req_o});
            end
            tick();
        end
        rst_i = 1'b0;
        settle();
        checks++;
        if ({miss_ready_o, busy_o, tag_we_o} !== 3'b100) begin
            errors++;
            $display("FAIL rmid_release: got ready/busy/we=%b expected 100", {miss_ready_o, busy_o, tag_we_o});
        end
        tick();
        l2_rsp_valid_i = 1'b0;
        settle();
        checks++;
        if ({miss_ready_o, busy_o, tag_we_o, data_we_o, flush_en_o, l2_req_valid_o, refill_done_o} !== 7'b1000000) begin
            errors++;
            $display("FAIL rmid_stray_rsp: got %b expected 1000000",
                     {miss_ready_o, busy_o, tag_we_o, data_we_o, flush_en_o, l2_req_valid_o, refill_done_o});
        end
    endtask

    initial begin
        rst_i = 1'b1;
        idle_inputs();
        test_reset();
        test_basic_refill();
        test_req_stall_error();
        test_flush_during_wait();
        test_flush_vs_miss();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sargantana_icache_refill_ctrl.md
# sargantana_icache_refill_ctrl

Instruction-cache refill and flush controller: the initiator side of the icache tag/data memory port. It accepts a miss (tag, set index, victim way), requests the line from the next memory level, and writes tag, valid bit and line into the selected way. It also sequences cache flushes. It sits between the icache lookup FSM, the L2 request/response channel and the tag/data memory arrays.

## Interface
- ICACHE_N_WAY, 4, number of ways; the victim and request masks are one-hot or all-ones over ways
- TAG_WIDHT, 20, tag width
- SET_WIDHT, 256, cache line width in bits
- ADDR_WIDHT, 6, set index width; number of sets = 2^ADDR_WIDHT
- clk_i  in  1  clock; all logic is on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- miss_valid_i  in  1  miss request from lookup
- miss_ready_o  out  1  controller can accept a miss
- miss_tag_i  in  TAG_WIDHT  tag of the missing line
- miss_idx_i  in  ADDR_WIDHT  set index of the missing line
- miss_way_i  in  ICACHE_N_WAY  one-hot victim way
- flush_i  in  1  flush request pulse
- busy_o  out  1  controller is not in IDLE, or a flush is pending
- refill_done_o  out  1  one-cycle pulse when the line write occurs
- flush_done_o  out  1  one-cycle pulse when the flush completes
- l2_req_valid_o / l2_req_ready_i  out/in  1  L2 request handshake
- l2_req_tag_o, l2_req_idx_o  out  TAG_WIDHT, ADDR_WIDHT  requested line address
- l2_rsp_valid_i  in  1  response beat; it is always accepted
- l2_rsp_data_i  in  SET_WIDHT  full line
- l2_rsp_error_i  in  1  bus error on the response
- tag_req_o, data_req_o  out  ICACHE_N_WAY  per-way array enables
- tag_we_o, data_we_o, flush_en_o, valid_bit_o  out  1  array controls
- tag_o, cline_o, addr_o  out  TAG_WIDHT, SET_WIDHT, ADDR_WIDHT  write tag, write line, set address

## Operation
- States: IDLE, REQ, WAIT, WRITE, FLUSH.
- IDLE:
  - miss_ready_o = !flush_i && !flush_pending.
  - On a miss handshake, latch tag, idx and way, then go to REQ.
  - flush_i or flush_pending goes to FLUSH. Flush has priority over a simultaneous miss, and that miss is not accepted.
- REQ:
  - l2_req_valid_o = 1 with the latched tag and idx.
  - The outputs stay stable until l2_req_ready_i; then go to WAIT.
- WAIT:
  - On l2_rsp_valid_i, latch data and error, then go to WRITE.
- WRITE (exactly 1 cycle):
  - tag_req_o = data_req_o = latched way; tag_we_o = data_we_o = 1.
  - addr_o = idx, tag_o = tag, cline_o = data, valid_bit_o = !error.
  - refill_done_o = 1; next state is IDLE.
- flush_i in any non-IDLE state sets flush_pending; the current refill completes first. flush_pending clears on entry to FLUSH.
- FLUSH behaviour is set by the configuration macro.
- Outside WRITE and FLUSH, all array enables and write strobes are 0.
- miss_way_i that is not one-hot is illegal; the bench asserts against it.

## Timing
- Reset: every output is 0 while rst_i is high (including miss_ready_o), state is IDLE, flush_pending = 0. miss_ready_o = 1 the first cycle after reset is released.
- A miss accepted in cycle N gives l2_req_valid_o high in N+1.
- Response in cycle M gives WRITE and refill_done_o in M+1, and miss_ready_o = 1 in M+2.
- Minimum miss-to-write latency is 3 cycles (L2 ready and response both zero-wait).
- Reset mid-operation aborts immediately: no write strobe in the reset cycle, pending flush dropped, any outstanding L2 response ignored.
- An l2_rsp_valid_i outside WAIT is ignored.

## Configuration
- ICACHE_FLUSH_WALK_EN defined:
  - FLUSH walks a counter from 0 to 2^ADDR_WIDHT-1, one set per cycle.
  - Per cycle: tag_req_o = all ones, tag_we_o = 1, valid_bit_o = 0, tag_o = 0, addr_o = counter, flush_en_o = 0.
  - flush_done_o pulses with the last set; next cycle is IDLE.
  - Duration is 2^ADDR_WIDHT cycles; counter wrap is not allowed.
- ICACHE_FLUSH_WALK_EN not defined:
  - FLUSH lasts 1 cycle: flush_en_o = 1, tag_req_o = all ones, tag_we_o = 0, flush_done_o = 1; then IDLE.

## Test plan
- Miss tag=0x12345, idx=5, way=4'b0100; L2 ready and response zero-wait, data=pattern A -> WRITE 3 cycles after acceptance with data_req_o=tag_req_o=4'b0100, addr_o=5, tag_o=0x12345, cline_o=A, valid_bit_o=1; refill_done_o 1 cycle.
- l2_req_ready_i held low 4 cycles -> l2_req_valid_o, tag and idx stable for all 5 cycles; exactly one request handshake.
- Response with l2_rsp_error_i=1 -> WRITE with valid_bit_o=0, data_we_o=1, refill_done_o=1.
- flush_i pulsed during WAIT -> refill completes, then FLUSH. With walk enabled: 64 cycles, addr_o 0..63, flush_done_o on addr_o=63. Without walk: a single flush_en_o cycle.
- flush_i and miss_valid_i in the same IDLE cycle -> miss_ready_o=0, FLUSH entered; miss accepted after flush_done_o.
- rst_i asserted in WAIT, then a stray l2_rsp_valid_i -> no write strobes; outputs 0 during reset; IDLE with miss_ready_o=1 after release.
